// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM read master that fetches the two-word system-ID slave
// (word 0 = system ID, word 1 = build timestamp) on a start pulse and compares each
// word against the identity this image was built to expect.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               1-cycle pulse, begins a check sequence (ignored unless idle)
//   avm_address         byte address of the current read (BASE_ADDR / BASE_ADDR+4)
//   avm_read            read request, held while avm_waitrequest is high
//   avm_waitrequest     slave stall
//   avm_readdata        read data, qualified by avm_readdatavalid
//   avm_readdatavalid   read data qualifier
//   busy                sequence in progress
//   done                1-cycle pulse when the sequence ends (normally or by timeout)
//   id_ok / ts_ok       word read back and matched its expected value
//   timeout             a transaction ran TIMEOUT cycles without returning data
//   id_value / ts_value captured words
module sysid_reader #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]       EXPECTED_ID = 32'd1804916800,
    parameter logic [31:0]       EXPECTED_TS = 32'd1329838582,
    parameter int unsigned       TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic              timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    // Last timer value of a transaction; expiring here means TIMEOUT cycles were spent.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReqId,
        StDatId,
        StReqTs,
        StDatTs,
        StFin
    } state_e;

    state_e state_q, state_d;

    logic              read_q, read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              id_ok_q, id_ok_d;
    logic              ts_ok_q, ts_ok_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       id_value_q, id_value_d;
    logic [31:0]       ts_value_q, ts_value_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic in_req;
    logic in_xfer;
    logic accept;
    logic got_id;
    logic got_ts;
    logic expire;

    always_comb begin
        in_req  = (state_q == StReqId) || (state_q == StReqTs);
        in_xfer = in_req || (state_q == StDatId) || (state_q == StDatTs);
        accept  = in_req && !avm_waitrequest;
        // Zero-latency slaves return data in the accept cycle itself.
        got_id  = avm_readdatavalid &&
                  ((state_q == StDatId) || ((state_q == StReqId) && accept));
        got_ts  = avm_readdatavalid &&
                  ((state_q == StDatTs) || ((state_q == StReqTs) && accept));
        // Data arriving on the last allowed cycle still counts.
        expire  = in_xfer && (timer_q == TIMER_LAST) && !(got_id || got_ts);
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            read_q     <= 1'b0;
            addr_q     <= BASE_ADDR;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StReqId;
            end
            StReqId: begin
                if (expire)      state_d = StFin;
                else if (got_id) state_d = StReqTs;
                else if (accept) state_d = StDatId;
            end
            StDatId: begin
                if (expire)      state_d = StFin;
                else if (got_id) state_d = StReqTs;
            end
            StReqTs: begin
                if (expire || got_ts) state_d = StFin;
                else if (accept)      state_d = StDatTs;
            end
            StDatTs: begin
                if (expire || got_ts) state_d = StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output / datapath next-values (all outputs are registered)
    always_comb begin
        read_d     = read_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        timer_d    = in_xfer ? timer_q + 1'b1 : timer_q;

        if (accept) begin
            read_d = 1'b0;
        end

        if ((state_q == StIdle) && start) begin
            read_d     = 1'b1;
            addr_d     = BASE_ADDR;
            busy_d     = 1'b1;
            id_ok_d    = 1'b0;
            ts_ok_d    = 1'b0;
            timeout_d  = 1'b0;
            id_value_d = '0;
            ts_value_d = '0;
            timer_d    = '0;
        end

        if (got_id) begin
            id_value_d = avm_readdata;
            id_ok_d    = (avm_readdata == EXPECTED_ID);
            // Issue the timestamp read straight away.
            read_d     = 1'b1;
            addr_d     = BASE_ADDR + ADDR_W'(4);
            timer_d    = '0;
        end

        if (got_ts) begin
            ts_value_d = avm_readdata;
            ts_ok_d    = (avm_readdata == EXPECTED_TS);
        end

        // Abandon the bus read; the slave's late response falls on an ignoring state.
        if (expire) begin
            timeout_d = 1'b1;
            read_d    = 1'b0;
        end

        if ((state_d == StFin) && (state_q != StFin)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: normal reads, slave stalls, ID/TS mismatch,
// response timeout, start while busy, mid-sequence reset, zero-latency slave.
module tb_sysid_reader;

    localparam logic [31:0] ID = 32'd1804916800;
    localparam logic [31:0] TS = 32'd1329838582;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;

    sysid_reader dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks,
                 errors);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of read data from the slave.
    task automatic beat(input logic [31:0] d);
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        step();
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        int ndone;
        logic saw_ts;

        reset_n           = 1'b0;
        start             = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idok", id_ok, 0);
        chk("rst_tsok", ts_ok, 0);
        chk("rst_tmo", timeout, 0);
        chk("rst_idval", id_value, 0);
        chk("rst_tsval", ts_value, 0);
        reset_n = 1'b1;
        step();

        // 1: no stall, data one cycle after accept
        pulse_start();
        chk("c1_busy", busy, 1);
        chk("c1_read_id", avm_read, 1);
        chk("c1_addr_id", avm_address, 0);
        step();
        chk("c1_read_drop", avm_read, 0);
        chk("c1_busy_dat", busy, 1);
        beat(ID);
        chk("c1_idval", id_value, ID);
        chk("c1_idok", id_ok, 1);
        chk("c1_read_ts", avm_read, 1);
        chk("c1_addr_ts", avm_address, 4);
        step();
        chk("c1_read_drop2", avm_read, 0);
        chk("c1_done_early", done, 0);
        beat(TS);
        chk("c1_done", done, 1);
        chk("c1_busy_fin", busy, 0);
        chk("c1_tsok", ts_ok, 1);
        chk("c1_tsval", ts_value, TS);
        chk("c1_tmo", timeout, 0);
        step();
        chk("c1_done_once", done, 0);
        chk("c1_hold_idok", id_ok, 1);

        // 2: waitrequest high for 3 cycles on word 0
        pulse_start();
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("c2_read_stall", avm_read, 1);
            chk("c2_addr_stall", avm_address, 0);
            step();
        end
        avm_waitrequest = 1'b0;
        chk("c2_read_acc", avm_read, 1);
        chk("c2_addr_acc", avm_address, 0);
        step();
        chk("c2_read_drop", avm_read, 0);
        beat(ID);
        chk("c2_addr_ts", avm_address, 4);
        step();
        beat(TS);
        chk("c2_done", done, 1);
        chk("c2_idok", id_ok, 1);
        chk("c2_tsok", ts_ok, 1);
        chk("c2_tmo", timeout, 0);
        step();

        // 3: timestamp word mismatches
        pulse_start();
        chk("c3_idok_clr", id_ok, 0);
        chk("c3_tsok_clr", ts_ok, 0);
        chk("c3_tsval_clr", ts_value, 0);
        step();
        beat(ID);
        step();
        beat(32'h0);
        chk("c3_done", done, 1);
        chk("c3_idok", id_ok, 1);
        chk("c3_tsok", ts_ok, 0);
        chk("c3_tsval", ts_value, 0);
        chk("c3_tmo", timeout, 0);
        step();
        // Stray readdatavalid while idle is ignored
        beat(32'hdeadbeef);
        chk("c3_idle_ignore", id_value, ID);

        // 4: word 0 never returns data
        pulse_start();
        n      = 0;
        saw_ts = 1'b0;
        while (n < 400 && !done) begin
            if (avm_read && avm_address == 32'd4) saw_ts = 1'b1;
            step();
            n++;
        end
        chk("c4_cycles", 32'(n), 255);
        chk("c4_tmo", timeout, 1);
        chk("c4_idok", id_ok, 0);
        chk("c4_tsok", ts_ok, 0);
        chk("c4_read", avm_read, 0);
        chk("c4_no_ts_read", saw_ts, 0);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) ndone++;
        end
        chk("c4_done_once", 32'(ndone), 0);
        chk("c4_tmo_hold", timeout, 1);

        // 5: start while busy ignored, reset during DAT_TS
        pulse_start();
        chk("c5_tmo_clr", timeout, 0);
        pulse_start();
        chk("c5_busy", busy, 1);
        chk("c5_read_drop", avm_read, 0);
        beat(ID);
        chk("c5_addr_ts", avm_address, 4);
        chk("c5_idok", id_ok, 1);
        step();
        chk("c5_read_dat", avm_read, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("c5_rst_busy", busy, 0);
        chk("c5_rst_done", done, 0);
        chk("c5_rst_idok", id_ok, 0);
        chk("c5_rst_idval", id_value, 0);
        chk("c5_rst_addr", avm_address, 0);
        chk("c5_rst_read", avm_read, 0);
        step();
        chk("c5_rst_nodone", done, 0);
        reset_n = 1'b1;
        step();
        chk("c5_idle", busy, 0);

        // 6: zero-latency slave, then start in FIN ignored
        pulse_start();
        avm_readdatavalid = 1'b1;
        avm_readdata      = ID;
        step();
        chk("c6_idval", id_value, ID);
        chk("c6_idok", id_ok, 1);
        chk("c6_read_ts", avm_read, 1);
        chk("c6_addr_ts", avm_address, 4);
        avm_readdata = TS;
        step();
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        chk("c6_done", done, 1);
        chk("c6_tsok", ts_ok, 1);
        chk("c6_tsval", ts_value, TS);
        chk("c6_read", avm_read, 0);
        pulse_start();
        chk("c6_fin_start_busy", busy, 0);
        chk("c6_fin_start_read", avm_read, 0);
        chk("c6_fin_done", done, 0);
        step();
        chk("c6_still_idle", busy, 0);
        chk("c6_hold_tsok", ts_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
